// File: rtl/alu_op_seq.sv
// Multi-cycle ALU sequencer: IDLE -> READ -> EXEC -> WB, one decoded ALU op at a time.
// Optional build macro ALU_SEQ_OVERLAP_EN: accept in WB (3-cycle throughput) with WB forwarding.
module alu_op_seq #(
    parameter int unsigned WORD_SIZE  = 16,
    parameter int unsigned REG_ADDR_W = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [3:0]            req_func,
    input  logic                  req_byte,
    input  logic [REG_ADDR_W-1:0] req_dst,
    input  logic [REG_ADDR_W-1:0] req_src,
    input  logic                  req_use_const,
    input  logic [WORD_SIZE-1:0]  req_const,
    input  logic                  req_wb_en,
    input  logic [3:0]            req_flags_en,
    output logic [REG_ADDR_W-1:0] rf_addr_a,
    output logic [REG_ADDR_W-1:0] rf_addr_b,
    input  logic [WORD_SIZE-1:0]  rf_data_a,
    input  logic [WORD_SIZE-1:0]  rf_data_b,
    output logic                  rf_we,
    output logic [REG_ADDR_W-1:0] rf_waddr,
    output logic [WORD_SIZE-1:0]  rf_wdata,
    output logic [3:0]            alu_func,
    output logic                  alu_byte,
    output logic                  alu_carry_in,
    output logic [WORD_SIZE-1:0]  alu_src_a,
    output logic [WORD_SIZE-1:0]  alu_src_b,
    input  logic [WORD_SIZE-1:0]  alu_result,
    input  logic [3:0]            alu_status,
    output logic [3:0]            psw,
    output logic                  done
);

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StRead = 2'd1;
    localparam logic [1:0] StExec = 2'd2;
    localparam logic [1:0] StWb   = 2'd3;

    logic [1:0]            state_q;
    logic [3:0]            func_q;
    logic                  byte_q;
    logic [REG_ADDR_W-1:0] dst_q;
    logic [REG_ADDR_W-1:0] src_q;
    logic                  use_const_q;
    logic [WORD_SIZE-1:0]  const_q;
    logic                  wb_en_q;
    logic [3:0]            flags_en_q;
    logic [WORD_SIZE-1:0]  res_q;
    logic [3:0]            psw_q;
    logic [3:0]            alu_func_q;
    logic                  alu_byte_q;
    logic                  alu_carry_in_q;
    logic [WORD_SIZE-1:0]  alu_src_a_q;
    logic [WORD_SIZE-1:0]  alu_src_b_q;
    logic                  accept;
    logic [3:0]            status_eff;
    logic [WORD_SIZE-1:0]  opnd_a;
    logic [WORD_SIZE-1:0]  opnd_b;

`ifdef ALU_SEQ_OVERLAP_EN
    logic                  fwd_a_q;
    logic                  fwd_b_q;
    logic [WORD_SIZE-1:0]  fwd_data_q;

    assign req_ready = (state_q == StIdle) || (state_q == StWb);
    assign opnd_a    = fwd_a_q ? fwd_data_q : rf_data_a;
    assign opnd_b    = fwd_b_q ? fwd_data_q : rf_data_b;
`else
    assign req_ready = (state_q == StIdle);
    assign opnd_a    = rf_data_a;
    assign opnd_b    = rf_data_b;
`endif

    assign accept = req_valid && req_ready;

    // Byte ops judge sign/zero on the low byte only; carry and overflow come from the ALU.
    always_comb begin
        status_eff = alu_status;
        if (byte_q) begin
            status_eff[2] = alu_result[7];
            status_eff[1] = (alu_result[7:0] == 8'd0);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= StIdle;
            func_q         <= '0;
            byte_q         <= 1'b0;
            dst_q          <= '0;
            src_q          <= '0;
            use_const_q    <= 1'b0;
            const_q        <= '0;
            wb_en_q        <= 1'b0;
            flags_en_q     <= '0;
            res_q          <= '0;
            psw_q          <= '0;
            alu_func_q     <= '0;
            alu_byte_q     <= 1'b0;
            alu_carry_in_q <= 1'b0;
            alu_src_a_q    <= '0;
            alu_src_b_q    <= '0;
`ifdef ALU_SEQ_OVERLAP_EN
            fwd_a_q        <= 1'b0;
            fwd_b_q        <= 1'b0;
            fwd_data_q     <= '0;
`endif
        end else begin
            case (state_q)
                StRead: begin
                    // ALU drive registers load here so they are stable for the whole EXEC cycle.
                    alu_src_a_q    <= opnd_a;
                    alu_src_b_q    <= use_const_q ? const_q : opnd_b;
                    alu_func_q     <= func_q;
                    alu_byte_q     <= byte_q;
                    alu_carry_in_q <= psw_q[0];
                    state_q        <= StExec;
                end
                StExec: begin
                    res_q   <= alu_result;
                    psw_q   <= (psw_q & ~flags_en_q) | (status_eff & flags_en_q);
                    state_q <= StWb;
                end
                StWb:    state_q <= StIdle;
                default: state_q <= StIdle;
            endcase

            if (accept) begin
                func_q      <= req_func;
                byte_q      <= req_byte;
                dst_q       <= req_dst;
                src_q       <= req_src;
                use_const_q <= req_use_const;
                const_q     <= req_const;
                wb_en_q     <= req_wb_en;
                flags_en_q  <= req_flags_en;
                state_q     <= StRead;
`ifdef ALU_SEQ_OVERLAP_EN
                // The register file returns pre-write data for this edge, so forward it.
                fwd_a_q     <= rf_we && (rf_waddr == req_dst);
                fwd_b_q     <= rf_we && (rf_waddr == req_src);
                fwd_data_q  <= rf_wdata;
`endif
            end
        end
    end

    assign rf_addr_a    = accept ? req_dst : dst_q;
    assign rf_addr_b    = accept ? req_src : src_q;
    assign done         = (state_q == StWb);
    assign rf_we        = done && wb_en_q;
    assign rf_waddr     = dst_q;
    assign rf_wdata     = byte_q ? {alu_src_a_q[WORD_SIZE-1:8], res_q[7:0]} : res_q;
    assign alu_func     = alu_func_q;
    assign alu_byte     = alu_byte_q;
    assign alu_carry_in = alu_carry_in_q;
    assign alu_src_a    = alu_src_a_q;
    assign alu_src_b    = alu_src_b_q;
    assign psw          = psw_q;

endmodule

// File: tb/tb_alu_op_seq.sv
// Directed bench for alu_op_seq with a behavioural register file and ALU around the DUT.
module tb_alu_op_seq;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [3:0]  req_func = '0;
  logic        req_byte = 1'b0;
  logic [2:0]  req_dst = '0;
  logic [2:0]  req_src = '0;
  logic        req_use_const = 1'b0;
  logic [15:0] req_const = '0;
  logic        req_wb_en = 1'b0;
  logic [3:0]  req_flags_en = '0;
  logic [2:0]  rf_addr_a, rf_addr_b, rf_waddr;
  logic [15:0] rf_data_a, rf_data_b, rf_wdata;
  logic        rf_we;
  logic [3:0]  alu_func;
  logic        alu_byte, alu_carry_in;
  logic [15:0] alu_src_a, alu_src_b, alu_result;
  logic [3:0]  alu_status, psw;
  logic        done;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  alu_op_seq #(.WORD_SIZE(16), .REG_ADDR_W(3)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_func(req_func), .req_byte(req_byte), .req_dst(req_dst), .req_src(req_src),
    .req_use_const(req_use_const), .req_const(req_const), .req_wb_en(req_wb_en),
    .req_flags_en(req_flags_en), .rf_addr_a(rf_addr_a), .rf_addr_b(rf_addr_b),
    .rf_data_a(rf_data_a), .rf_data_b(rf_data_b), .rf_we(rf_we), .rf_waddr(rf_waddr),
    .rf_wdata(rf_wdata), .alu_func(alu_func), .alu_byte(alu_byte),
    .alu_carry_in(alu_carry_in), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .alu_result(alu_result), .alu_status(alu_status), .psw(psw), .done(done)
  );

  // Register file: synchronous read, DUT write has priority over bench preload.
  logic [15:0] regs [8];
  logic        ld_we = 1'b0;
  logic [2:0]  ld_addr = '0;
  logic [15:0] ld_data = '0;

  always @(posedge clk) begin
    if (rf_we) regs[rf_waddr] <= rf_wdata;
    else if (ld_we) regs[ld_addr] <= ld_data;
    rf_data_a <= regs[rf_addr_a];
    rf_data_b <= regs[rf_addr_b];
  end

  // ALU: arithmetic block {ADD, ADDC, SUB, SUBC}; C is the byte carry in byte mode.
  logic [15:0] bb, r;
  logic        ci, c, v;
  logic [16:0] s17;
  logic [8:0]  s9;
  always_comb begin
    bb  = alu_func[1] ? ~alu_src_b : alu_src_b;
    ci  = alu_func[0] ? alu_carry_in : alu_func[1];
    s17 = {1'b0, alu_src_a} + {1'b0, bb} + {16'd0, ci};
    s9  = {1'b0, alu_src_a[7:0]} + {1'b0, bb[7:0]} + {8'd0, ci};
    r   = '0;
    c   = 1'b0;
    v   = 1'b0;
    case (alu_func[3:2])
      2'd0: begin
        r = s17[15:0];
        c = alu_byte ? s9[8] : s17[16];
        v = (alu_src_a[15] == bb[15]) && (r[15] != alu_src_a[15]);
      end
      2'd1: begin
        case (alu_func[1:0])
          2'd0:    r = alu_src_a & alu_src_b;
          2'd1:    r = alu_src_a | alu_src_b;
          2'd2:    r = alu_src_a ^ alu_src_b;
          default: r = ~alu_src_b;
        endcase
      end
      2'd2: begin
        r = alu_src_a << 1;
        c = alu_src_a[15];
      end
      default: r = alu_src_b;
    endcase
    alu_result = r;
    alu_status = {v, r[15], (r == 16'd0), c};
  end

  int          lat, done_cnt;
  logic        we_seen, cin_ex, rdy_mid, rdy_wb;
  logic [2:0]  wa;
  logic [15:0] wd;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_reg(input logic [2:0] a, input logic [15:0] d);
    @(negedge clk);
    ld_we = 1'b1; ld_addr = a; ld_data = d;
    @(posedge clk);
    #1 ld_we = 1'b0;
  endtask

  task automatic drive_req(input logic [3:0] f, input logic bt, input logic [2:0] d,
                           input logic [2:0] s, input logic uc, input logic [15:0] k,
                           input logic wb, input logic [3:0] fe);
    req_func = f; req_byte = bt; req_dst = d; req_src = s; req_use_const = uc;
    req_const = k; req_wb_en = wb; req_flags_en = fe; req_valid = 1'b1;
    @(posedge clk);
    #1;
    // Fields only need to be valid in the accept cycle; scramble them afterwards.
    req_valid = 1'b0; req_dst = ~d; req_src = ~s; req_const = 16'hDEAD;
    req_func = ~f; req_byte = ~bt; req_flags_en = ~fe; req_wb_en = ~wb;
  endtask

  // Observes a fixed 6-cycle window after the accept edge; a missing done leaves lat at 0.
  task automatic observe();
    lat = 0; done_cnt = 0; we_seen = 1'b0; wa = '0; wd = '0;
    for (int n = 1; n <= 6; n++) begin
      @(negedge clk);
      if (n == 1) rdy_mid = req_ready;
      if (n == 2) cin_ex = alu_carry_in;
      if (n == 3) rdy_wb = req_ready;
      if (done) begin
        done_cnt++;
        if (lat == 0) lat = n;
      end
      if (rf_we) begin
        we_seen = 1'b1; wa = rf_waddr; wd = rf_wdata;
      end
    end
  endtask

  task automatic run_op(input logic [3:0] f, input logic bt, input logic [2:0] d,
                        input logic [2:0] s, input logic uc, input logic [15:0] k,
                        input logic wb, input logic [3:0] fe);
    @(negedge clk);
    drive_req(f, bt, d, s, uc, k, wb, fe);
    observe();
  endtask

  initial begin
    for (int i = 0; i < 8; i++) regs[i] = 16'd0;
    #12;
    chk("rst_ready", req_ready, 1'b1);
    chk("rst_psw", psw, 4'h0);
    chk("rst_done", done, 1'b0);
    chk("rst_we", rf_we, 1'b0);
    chk("rst_srca", alu_src_a, 16'h0000);
    @(negedge clk);
    rst_n = 1'b1;

    // ADD R1=5 + R2=3
    set_reg(3'd1, 16'h0005);
    set_reg(3'd2, 16'h0003);
    run_op(4'b0000, 1'b0, 3'd1, 3'd2, 1'b0, 16'h0, 1'b1, 4'b1111);
    chk("add_lat", lat, 3);
    chk("add_ready_busy", rdy_mid, 1'b0);
    chk("add_we", we_seen, 1'b1);
    chk("add_waddr", wa, 3'd1);
    chk("add_wdata", wd, 16'h0008);
    chk("add_done_cnt", done_cnt, 1);
    chk("add_psw", psw, 4'b0000);
    chk("add_regfile", regs[1], 16'h0008);
`ifdef ALU_SEQ_OVERLAP_EN
    chk("wb_ready", rdy_wb, 1'b1);
`else
    chk("wb_ready", rdy_wb, 1'b0);
`endif

    // Byte ADD 0x12FF + const 1: low byte wraps to 0, Z/S from low byte, C from ALU
    set_reg(3'd1, 16'h12FF);
    run_op(4'b0000, 1'b1, 3'd1, 3'd0, 1'b1, 16'h0001, 1'b1, 4'b1111);
    chk("badd_wdata", wd, 16'h1200);
    chk("badd_psw", psw, 4'b0011);

    // SUB R3=4 - const 4, compare only
    set_reg(3'd3, 16'h0004);
    run_op(4'b0010, 1'b0, 3'd3, 3'd0, 1'b1, 16'h0004, 1'b0, 4'b1111);
    chk("cmp_we", we_seen, 1'b0);
    chk("cmp_done_cnt", done_cnt, 1);
    chk("cmp_psw", psw, 4'b0011);

    // Set psw=0001 (C only), then ADDC R0=0xFFFF + 0 with only C enabled
    set_reg(3'd0, 16'hFFFF);
    run_op(4'b0000, 1'b0, 3'd0, 3'd0, 1'b1, 16'h0002, 1'b0, 4'b1111);
    chk("setc_psw", psw, 4'b0001);
    run_op(4'b0001, 1'b0, 3'd0, 3'd0, 1'b1, 16'h0000, 1'b1, 4'b0001);
    chk("addc_cin", cin_ex, 1'b1);
    chk("addc_wdata", wd, 16'h0000);
    chk("addc_psw", psw, 4'b0001);

    // Reset asserted during EXEC drops the op
    set_reg(3'd1, 16'h0005);
    @(negedge clk);
    drive_req(4'b0000, 1'b0, 3'd1, 3'd2, 1'b0, 16'h0, 1'b1, 4'b1111);
    @(negedge clk);
    @(negedge clk);
    chk("exec_srca", alu_src_a, 16'h0005);
    rst_n = 1'b0;
    #1;
    chk("rstx_psw", psw, 4'h0);
    chk("rstx_ready", req_ready, 1'b1);
    chk("rstx_done", done, 1'b0);
    chk("rstx_srca", alu_src_a, 16'h0000);
    we_seen = 1'b0; done_cnt = 0;
    for (int n = 0; n < 3; n++) begin
      @(posedge clk);
      #1;
      if (rf_we) we_seen = 1'b1;
      if (done) done_cnt++;
    end
    chk("rstx_no_we", we_seen, 1'b0);
    chk("rstx_no_done", done_cnt, 0);
    chk("rstx_r1", regs[1], 16'h0005);
    @(negedge clk);
    rst_n = 1'b1;
    run_op(4'b0000, 1'b0, 3'd1, 3'd2, 1'b0, 16'h0, 1'b1, 4'b1111);
    chk("post_lat", lat, 3);
    chk("post_wdata", wd, 16'h0008);

`ifdef ALU_SEQ_OVERLAP_EN
    // ADD R1=5+3 then MOV R1->R2 accepted in WB, operand forwarded from rf_wdata
    set_reg(3'd1, 16'h0005);
    @(negedge clk);
    drive_req(4'b0000, 1'b0, 3'd1, 3'd2, 1'b0, 16'h0, 1'b1, 4'b1111);
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    chk("ov_first_done", done, 1'b1);
    drive_req(4'b1100, 1'b0, 3'd2, 3'd1, 1'b0, 16'h0, 1'b1, 4'b0000);
    lat = 0; wa = '0; wd = '0;
    for (int n = 1; n <= 6; n++) begin
      @(negedge clk);
      if (n == 2) chk("ov_fwd_srcb", alu_src_b, 16'h0008);
      if (done && lat == 0) begin
        lat = n; wa = rf_waddr; wd = rf_wdata;
      end
    end
    chk("ov_lat", lat, 3);
    chk("ov_waddr", wa, 3'd2);
    chk("ov_wdata", wd, 16'h0008);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/alu_op_seq.md
# alu_op_seq

Multi-cycle sequencer that owns the ALU datapath and executes one decoded ALU instruction at a time. It accepts a request from the control unit over a valid/ready handshake, reads operands from the register file, drives the ALU, then commits the result to the register file and the selected bits to the processor status word (PSW). It sits between the instruction decoder, the register file and the ALU, and is the only block that drives the ALU inputs.

## Interface
- WORD_SIZE, 16, datapath width
- REG_ADDR_W, 3, register-file address width
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- req_valid  in  1  request present
- req_ready  out  1  sequencer can accept a request
- req_func  in  4  ALU function: [3:2] block (0 arithmetic, 1 logic, 2 shifter, 3 manipulation), [1:0] function within block
- req_byte  in  1  byte operation
- req_dst  in  REG_ADDR_W  destination register; also operand A
- req_src  in  REG_ADDR_W  source register (operand B)
- req_use_const  in  1  operand B = req_const instead of register
- req_const  in  WORD_SIZE  constant operand
- req_wb_en  in  1  write result to req_dst
- req_flags_en  in  4  per-bit PSW update enable {V,S,Z,C}
- rf_addr_a / rf_addr_b  out  REG_ADDR_W  register-file read addresses (synchronous read, data valid the following cycle)
- rf_data_a / rf_data_b  in  WORD_SIZE  register-file read data
- rf_we  out  1  register-file write strobe
- rf_waddr  out  REG_ADDR_W  write address
- rf_wdata  out  WORD_SIZE  write data
- alu_func  out  4, alu_byte  out  1, alu_carry_in  out  1, alu_src_a / alu_src_b  out  WORD_SIZE  ALU drive
- alu_result  in  WORD_SIZE, alu_status  in  4 {V,S,Z,C}  ALU outputs (combinational)
- psw  out  4  status register {V,S,Z,C}
- done  out  1  one-cycle pulse on commit

## Operation
- States: IDLE, READ, EXEC, WB.
- IDLE: req_ready=1. On req_valid&req_ready, latch all req_* fields, drive rf_addr_a=req_dst and rf_addr_b=req_src, go to READ.
- READ: capture op_a=rf_data_a and op_b = req_use_const ? const : rf_data_b; go to EXEC.
- EXEC: alu_src_a=op_a, alu_src_b=op_b, alu_func/alu_byte from the latch, alu_carry_in=psw[C]. Register alu_result into res. Each PSW bit with its flags_en bit set loads from alu_status; the remaining bits hold. For byte ops, Z = (alu_result[7:0]==0) and S = alu_result[7] replace the ALU values; C and V are taken from the ALU unchanged. Go to WB.
- WB: done=1. If wb_en: rf_we=1, rf_waddr=dst, rf_wdata = byte ? {op_a[15:8], res[7:0]} : res. Go to IDLE.
- In IDLE, READ and WB, the ALU drive outputs hold their last EXEC values; they return to 0 only on reset.
- A request with wb_en=0 (compare/test) updates the PSW only.

## Timing
- Accept edge = cycle 0. Operands are captured at the end of READ (cycle 1), the ALU is evaluated and PSW is written at the end of EXEC (cycle 2), and rf_we and done are high during cycle 3.
- Throughput: one instruction per 4 cycles (base build). req_ready is high only in IDLE.
- Handshake: request fields must be stable only in the accept cycle; holding req_valid without req_ready has no effect.
- Reset (asynchronous, any state): state=IDLE. All outputs are 0 except req_ready=1, and psw=0. An in-flight operation is dropped with no rf_we and no PSW change after reset assertion.
- A PSW update in EXEC is visible as alu_carry_in for the next instruction's EXEC.

## Configuration
- ALU_SEQ_OVERLAP_EN defined: req_ready is also high in WB. A request accepted in WB goes directly to READ, giving 3 cycles per instruction. If the new request reads the register being written in that WB cycle (rf_we=1 and address match on A or B), the sequencer captures the operand from rf_wdata instead of the register file.
- Not defined: req_ready is high in IDLE only, and there is no forwarding logic.

## Test plan
- R1=0x0005, R2=0x0003, ADD (func 0000) dst=R1, src=R2, flags_en=1111 -> cycle 3: rf_we=1, waddr=1, wdata=0x0008, done=1; psw=0000.
- R1=0x12FF, byte ADD with const 0x0001, flags_en=1111 -> wdata=0x12 00, Z=1, S=0; C is taken from alu_status.
- R3=0x0004, SUB (0010) with const 0x0004, wb_en=0 -> rf_we never asserted, psw Z=1, done pulses once.
- psw C=1, ADDC (0001) R0=0xFFFF + const 0x0000 with flags_en=0001 -> alu_carry_in=1, wdata=0x0000, only C updates.
- Assert rst_n=0 during EXEC of an ADD -> no rf_we and no done; psw=0 and req_ready=1 immediately; next request completes normally.
- With ALU_SEQ_OVERLAP_EN: ADD writing R1=0x0008 followed by a request accepted in WB, MOV R1→R2 -> second instruction's op_b=0x0008 (forwarded), its done arrives 3 cycles after the first done.
